// File: rtl/ifu_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channel plus the
// {pc, inst} hand-off to decode. The master side is the fetch unit.
interface ifu_fetch_if #(
  parameter int ADDR_W = 64,
  parameter int INST_W = 32
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic [INST_W-1:0] mem_rsp_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [INST_W-1:0] out_inst;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output out_valid, out_pc, out_inst,
    input  out_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  out_valid, out_pc, out_inst,
    output out_ready
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, keeps at most one memory read in flight,
// and hands {pc, inst} to decode; redirect squashes in-flight work, halt blocks issue.
module ifu_fetch #(
  parameter int              ADDR_W   = 64,
  parameter int              INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  ifu_fetch_if.master       fetch_bus,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              halt_i
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              drop_q, drop_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;
  logic [INST_W-1:0] out_inst_q, out_inst_d;

  logic              req_fire_s;
  logic [ADDR_W-1:0] redirect_tgt_s;
  logic [ADDR_W-1:0] pc_inc_s;

  assign req_fire_s     = (state_q == S_REQ) && !halt_i && fetch_bus.mem_req_ready;
  assign redirect_tgt_s = redirect_pc_i & ~{{(ADDR_W-2){1'b0}}, 2'b11};
  assign pc_inc_s       = pc_q + {{(ADDR_W-3){1'b0}}, 3'b100};

  // State register and all datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_pc_q    <= {ADDR_W{1'b0}};
      out_inst_q  <= {INST_W{1'b0}};
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
    end
  end

  // Next-state and datapath update; redirect overrides every other PC source
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_d      = drop_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;
    case (state_q)
      S_REQ: begin
        if (req_fire_s) begin
          state_d = S_WAIT;
          if (redirect_valid_i) begin
            pc_d   = redirect_tgt_s;
            drop_d = 1'b1;
          end else begin
            drop_d = 1'b0;
          end
        end else if (redirect_valid_i) begin
          pc_d = redirect_tgt_s;
        end else begin
          pc_d = pc_q;
        end
      end
      S_WAIT: begin
        if (redirect_valid_i) begin
          pc_d = redirect_tgt_s;
          if (fetch_bus.mem_rsp_valid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (fetch_bus.mem_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            out_inst_d  = fetch_bus.mem_rsp_data;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            state_d     = S_OUT;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_OUT: begin
        // A redirect still lets a simultaneous out handshake count, but suppresses pc+4
        if (redirect_valid_i) begin
          out_valid_d = 1'b0;
          pc_d        = redirect_tgt_s;
          state_d     = S_REQ;
        end else if (fetch_bus.out_ready) begin
          out_valid_d = 1'b0;
          pc_d        = pc_inc_s;
          state_d     = S_REQ;
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        state_d     = S_REQ;
        out_valid_d = 1'b0;
        drop_d      = 1'b0;
      end
    endcase
  end

  // Output decode: request is combinational from state/pc, decode side is registered
  always_comb begin
    fetch_bus.mem_req_addr = pc_q;
    if (rst_n && (state_q == S_REQ) && !halt_i) begin
      fetch_bus.mem_req_valid = 1'b1;
    end else begin
      fetch_bus.mem_req_valid = 1'b0;
    end
    fetch_bus.out_valid = out_valid_q;
    fetch_bus.out_pc    = out_pc_q;
    fetch_bus.out_inst  = out_inst_q;
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a default-reset instance for the fetch/redirect/halt
// scenarios and a second instance whose reset PC sits at the top of the address space.
module tb_ifu_fetch;

  logic        clk;
  logic        rst_n_a;
  logic        rst_n_b;
  logic        redir_a;
  logic [63:0] redir_pc_a;
  logic        halt_a;
  logic        redir_b;
  logic [63:0] redir_pc_b;
  logic        halt_b;

  int checks;
  int failures;

  ifu_fetch_if #(.ADDR_W(64), .INST_W(32)) bus_a ();
  ifu_fetch_if #(.ADDR_W(64), .INST_W(32)) bus_b ();

  ifu_fetch #(.ADDR_W(64), .INST_W(32), .RESET_PC(64'h0000_0000_8000_0000)) dut_a (
    .clk              (clk),
    .rst_n            (rst_n_a),
    .fetch_bus        (bus_a),
    .redirect_valid_i (redir_a),
    .redirect_pc_i    (redir_pc_a),
    .halt_i           (halt_a)
  );

  ifu_fetch #(.ADDR_W(64), .INST_W(32), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_b (
    .clk              (clk),
    .rst_n            (rst_n_b),
    .fetch_bus        (bus_b),
    .redirect_valid_i (redir_b),
    .redirect_pc_i    (redir_pc_b),
    .halt_i           (halt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    redir_a = 1'b0; redir_pc_a = 64'd0; halt_a = 1'b0;
    redir_b = 1'b0; redir_pc_b = 64'd0; halt_b = 1'b0;
    bus_a.mem_req_ready = 1'b0; bus_a.mem_rsp_valid = 1'b0; bus_a.mem_rsp_data = 32'd0; bus_a.out_ready = 1'b0;
    bus_b.mem_req_ready = 1'b0; bus_b.mem_rsp_valid = 1'b0; bus_b.mem_rsp_data = 32'd0; bus_b.out_ready = 1'b0;

    // Reset values
    #2;
    chk("rst_req_valid", 64'(bus_a.mem_req_valid), 64'd0);
    chk("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    chk("rst_out_pc", bus_a.out_pc, 64'd0);
    chk("rst_out_inst", 64'(bus_a.out_inst), 64'd0);
    tick(); tick();

    // 1: first fetch from RESET_PC
    rst_n_a = 1'b1;
    bus_a.mem_req_ready = 1'b1;
    #1;
    chk("t1_req_valid", 64'(bus_a.mem_req_valid), 64'd1);
    chk("t1_req_addr", bus_a.mem_req_addr, 64'h0000_0000_8000_0000);
    tick();
    chk("t1_wait_no_req", 64'(bus_a.mem_req_valid), 64'd0);
    bus_a.mem_rsp_valid = 1'b1; bus_a.mem_rsp_data = 32'h0010_0073;
    tick();
    bus_a.mem_rsp_valid = 1'b0;
    chk("t1_out_valid", 64'(bus_a.out_valid), 64'd1);
    chk("t1_out_pc", bus_a.out_pc, 64'h0000_0000_8000_0000);
    chk("t1_out_inst", 64'(bus_a.out_inst), 64'h0010_0073);

    // 2: decode stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_valid", 64'(bus_a.out_valid), 64'd1);
      chk("t2_hold_pc", bus_a.out_pc, 64'h0000_0000_8000_0000);
      chk("t2_hold_inst", 64'(bus_a.out_inst), 64'h0010_0073);
      chk("t2_no_req", 64'(bus_a.mem_req_valid), 64'd0);
    end
    bus_a.out_ready = 1'b1;
    tick();
    chk("t2_out_drop", 64'(bus_a.out_valid), 64'd0);
    chk("t2_req_valid", 64'(bus_a.mem_req_valid), 64'd1);
    chk("t2_req_addr", bus_a.mem_req_addr, 64'h0000_0000_8000_0004);
    tick();
    bus_a.mem_rsp_valid = 1'b1; bus_a.mem_rsp_data = 32'h0000_0013;
    tick();
    bus_a.mem_rsp_valid = 1'b0;
    chk("t2_out_pc2", bus_a.out_pc, 64'h0000_0000_8000_0004);
    chk("t2_out_inst2", 64'(bus_a.out_inst), 64'h0000_0013);
    tick();
    chk("t2_req_addr3", bus_a.mem_req_addr, 64'h0000_0000_8000_0008);

    // 3: redirect while waiting, response arrives later and is dropped
    tick();
    redir_a = 1'b1; redir_pc_a = 64'h0000_0000_8000_1002;
    tick();
    redir_a = 1'b0;
    chk("t3_wait_no_req", 64'(bus_a.mem_req_valid), 64'd0);
    tick(); tick();
    bus_a.mem_rsp_valid = 1'b1; bus_a.mem_rsp_data = 32'hDEAD_BEEF;
    tick();
    bus_a.mem_rsp_valid = 1'b0;
    chk("t3_dropped_no_out", 64'(bus_a.out_valid), 64'd0);
    chk("t3_req_valid", 64'(bus_a.mem_req_valid), 64'd1);
    chk("t3_req_addr", bus_a.mem_req_addr, 64'h0000_0000_8000_1000);
    tick();
    bus_a.mem_rsp_valid = 1'b1; bus_a.mem_rsp_data = 32'h1111_1111;
    tick();
    bus_a.mem_rsp_valid = 1'b0;
    chk("t3_out_pc", bus_a.out_pc, 64'h0000_0000_8000_1000);
    chk("t3_out_inst", 64'(bus_a.out_inst), 64'h1111_1111);

    // 4b: redirect coincides with out handshake (out_ready still high)
    redir_a = 1'b1; redir_pc_a = 64'h0000_0000_8000_2000;
    tick();
    redir_a = 1'b0;
    chk("t4b_out_valid", 64'(bus_a.out_valid), 64'd0);
    chk("t4b_req_valid", 64'(bus_a.mem_req_valid), 64'd1);
    chk("t4b_req_addr", bus_a.mem_req_addr, 64'h0000_0000_8000_2000);

    // 4a: redirect coincides with request handshake
    redir_a = 1'b1; redir_pc_a = 64'h0000_0000_8000_3000;
    tick();
    redir_a = 1'b0;
    chk("t4a_wait_no_req", 64'(bus_a.mem_req_valid), 64'd0);
    bus_a.mem_rsp_valid = 1'b1; bus_a.mem_rsp_data = 32'hBAD0_BAD0;
    tick();
    bus_a.mem_rsp_valid = 1'b0;
    chk("t4a_no_out", 64'(bus_a.out_valid), 64'd0);
    chk("t4a_req_valid", 64'(bus_a.mem_req_valid), 64'd1);
    chk("t4a_req_addr", bus_a.mem_req_addr, 64'h0000_0000_8000_3000);

    // 5: halt blocks issue only
    halt_a = 1'b1;
    #1;
    chk("t5_halt_now", 64'(bus_a.mem_req_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_halt_hold", 64'(bus_a.mem_req_valid), 64'd0);
    end
    halt_a = 1'b0;
    #1;
    chk("t5_resume_valid", 64'(bus_a.mem_req_valid), 64'd1);
    chk("t5_resume_addr", bus_a.mem_req_addr, 64'h0000_0000_8000_3000);
    tick();
    halt_a = 1'b1;
    bus_a.mem_rsp_valid = 1'b1; bus_a.mem_rsp_data = 32'h2222_2222;
    tick();
    bus_a.mem_rsp_valid = 1'b0;
    chk("t5_out_valid", 64'(bus_a.out_valid), 64'd1);
    chk("t5_out_pc", bus_a.out_pc, 64'h0000_0000_8000_3000);
    chk("t5_out_inst", 64'(bus_a.out_inst), 64'h2222_2222);
    tick();
    chk("t5_out_done", 64'(bus_a.out_valid), 64'd0);
    chk("t5_halted_req", 64'(bus_a.mem_req_valid), 64'd0);
    halt_a = 1'b0;
    bus_a.mem_req_ready = 1'b0;
    #1;
    chk("t5_next_addr", bus_a.mem_req_addr, 64'h0000_0000_8000_3004);
    tick();
    chk("t5_req_held", 64'(bus_a.mem_req_valid), 64'd1);

    // 6a: reset asserted in S_WAIT, late response after release ignored
    bus_a.mem_req_ready = 1'b1;
    tick();
    chk("t6_in_wait", 64'(bus_a.mem_req_valid), 64'd0);
    rst_n_a = 1'b0;
    #1;
    chk("t6_rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    chk("t6_rst_out_pc", bus_a.out_pc, 64'd0);
    chk("t6_rst_req_valid", 64'(bus_a.mem_req_valid), 64'd0);
    tick();
    rst_n_a = 1'b1;
    bus_a.mem_req_ready = 1'b0;
    bus_a.mem_rsp_valid = 1'b1; bus_a.mem_rsp_data = 32'h3333_3333;
    tick();
    bus_a.mem_rsp_valid = 1'b0;
    chk("t6_late_rsp_out", 64'(bus_a.out_valid), 64'd0);
    chk("t6_refetch_valid", 64'(bus_a.mem_req_valid), 64'd1);
    chk("t6_refetch_addr", bus_a.mem_req_addr, 64'h0000_0000_8000_0000);

    // 6b: PC wraps from the top of the address space
    rst_n_b = 1'b1;
    bus_b.mem_req_ready = 1'b1;
    #1;
    chk("t6b_req_addr", bus_b.mem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    bus_b.mem_rsp_valid = 1'b1; bus_b.mem_rsp_data = 32'h4444_4444;
    tick();
    bus_b.mem_rsp_valid = 1'b0;
    bus_b.out_ready = 1'b1;
    chk("t6b_out_pc", bus_b.out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    chk("t6b_wrap_valid", 64'(bus_b.mem_req_valid), 64'd1);
    chk("t6b_wrap_addr", bus_b.mem_req_addr, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
